// File: rtl/chdr_strs_pkt_gen.sv
// CHDR stream-status (STRS) packet generator: turns one request into a 5-beat
// CHDR packet on a 64-bit AXI-Stream master and stamps a wrapping sequence number.
module chdr_strs_pkt_gen #(
    parameter int CHDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_dst_epid,
    input  logic [15:0]       req_src_epid,
    input  logic [3:0]        req_status,
    input  logic [39:0]       req_capacity_bytes,
    input  logic [23:0]       req_capacity_pkts,
    input  logic [39:0]       req_xfer_count_pkts,
    input  logic [63:0]       req_xfer_count_bytes,
    input  logic [15:0]       req_buff_info,
    input  logic [47:0]       req_status_info,
    output logic [CHDR_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [15:0]       seq_num
);

    if (CHDR_W != 64) begin : g_bad_chdr_w
        $error("chdr_strs_pkt_gen: CHDR_W must be 64");
    end

    typedef enum logic [2:0] {IDLE, HDR, W0, W1, W2, W3} state_t;

    localparam logic [5:0]  HDR_FLAGS     = 6'd0;
    localparam logic [2:0]  PKT_TYPE_STRS = 3'd1;
    localparam logic [6:0]  NUM_MDATA     = 7'd0;
    localparam logic [15:0] STRS_LEN      = 16'd40;

    state_t      state, state_nxt;
    logic        req_fire;
    logic        beat_fire;
    logic [15:0] seq_q;

    logic [15:0] dst_epid_p0;
    logic [15:0] src_epid_p0;
    logic [3:0]  status_p0;
    logic [39:0] capacity_bytes_p0;
    logic [23:0] capacity_pkts_p0;
    logic [39:0] xfer_count_pkts_p0;
    logic [63:0] xfer_count_bytes_p0;
    logic [15:0] buff_info_p0;
    logic [47:0] status_info_p0;

    assign req_fire  = req_valid && req_ready;
    assign beat_fire = m_axis_tvalid && m_axis_tready;
    assign seq_num   = seq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture: fields are frozen for the whole packet, so the source
    // may change them freely once the request has been taken.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            dst_epid_p0         <= req_dst_epid;
            src_epid_p0         <= req_src_epid;
            status_p0           <= req_status;
            capacity_bytes_p0   <= req_capacity_bytes;
            capacity_pkts_p0    <= req_capacity_pkts;
            xfer_count_pkts_p0  <= req_xfer_count_pkts;
            xfer_count_bytes_p0 <= req_xfer_count_bytes;
            buff_info_p0        <= req_buff_info;
            status_info_p0      <= req_status_info;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= 16'd0;
        end else if (beat_fire && (state == W3)) begin
            seq_q <= seq_q + 16'd1;
        end
    end

    // Beat contents are a pure function of state and captured fields, which
    // keeps tdata/tlast stable across any number of stalled cycles.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {HDR_FLAGS, PKT_TYPE_STRS, NUM_MDATA, seq_q,
                                 STRS_LEN, dst_epid_p0};
                if (m_axis_tready) begin
                    state_nxt = W0;
                end
            end
            W0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {capacity_bytes_p0, 4'b0000, status_p0, src_epid_p0};
                if (m_axis_tready) begin
                    state_nxt = W1;
                end
            end
            W1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {xfer_count_pkts_p0, capacity_pkts_p0};
                if (m_axis_tready) begin
                    state_nxt = W2;
                end
            end
            W2: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = xfer_count_bytes_p0;
                if (m_axis_tready) begin
                    state_nxt = W3;
                end
            end
            W3: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = {status_info_p0, buff_info_p0};
                if (m_axis_tready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_chdr_strs_pkt_gen.sv
// Directed bench for chdr_strs_pkt_gen: a negedge monitor compares every cycle
// against a queue of expected beats pushed when a request is taken.
module tb_chdr_strs_pkt_gen;

    typedef struct packed {
        logic [15:0] dst;
        logic [15:0] src;
        logic [3:0]  status;
        logic [39:0] cap_bytes;
        logic [23:0] cap_pkts;
        logic [39:0] xfer_pkts;
        logic [63:0] xfer_bytes;
        logic [15:0] buff_info;
        logic [47:0] status_info;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    req_t        cur;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] seq_num;

    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    int          nlast  = 0;
    int          n_acc  = 0;
    logic [15:0] model_seq = 16'd0;
    beat_t       q[$];
    logic [63:0] cap [0:4];
    logic        rand_mode = 1'b0;
    logic        tready_fix = 1'b1;

    chdr_strs_pkt_gen #(.CHDR_W(64)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_dst_epid        (cur.dst),
        .req_src_epid        (cur.src),
        .req_status          (cur.status),
        .req_capacity_bytes  (cur.cap_bytes),
        .req_capacity_pkts   (cur.cap_pkts),
        .req_xfer_count_pkts (cur.xfer_pkts),
        .req_xfer_count_bytes(cur.xfer_bytes),
        .req_buff_info       (cur.buff_info),
        .req_status_info     (cur.status_info),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .seq_num             (seq_num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_pkt(input req_t r, input logic [15:0] s);
        q.push_back(beat_t'{data: {6'd0, 3'd1, 7'd0, s, 16'd40, r.dst}, last: 1'b0});
        q.push_back(beat_t'{data: {r.cap_bytes, 4'd0, r.status, r.src}, last: 1'b0});
        q.push_back(beat_t'{data: {r.xfer_pkts, r.cap_pkts}, last: 1'b0});
        q.push_back(beat_t'{data: r.xfer_bytes, last: 1'b0});
        q.push_back(beat_t'{data: {r.status_info, r.buff_info}, last: 1'b1});
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.dst         = 16'($urandom);
        r.src         = 16'($urandom);
        r.status      = 4'($urandom);
        r.cap_bytes   = 40'({$urandom, $urandom});
        r.cap_pkts    = 24'($urandom);
        r.xfer_pkts   = 40'({$urandom, $urandom});
        r.xfer_bytes  = {$urandom, $urandom};
        r.buff_info   = 16'($urandom);
        r.status_info = 48'({$urandom, $urandom});
        return r;
    endfunction

    // tready is updated 2 time units after each edge so directed changes made
    // at edge+1 take effect in the same cycle.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_fix;
        end
    end

    initial begin
        bit exp_ready;
        int idx;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                model_seq = 16'd0;
            end else begin
                exp_ready = (q.size() == 0);
                check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
                check("tvalid", {63'd0, m_axis_tvalid}, {63'd0, !exp_ready});
                check("seq_num", {48'd0, seq_num}, {48'd0, model_seq});
                if (!exp_ready) begin
                    check("tdata", m_axis_tdata, q[0].data);
                    check("tlast", {63'd0, m_axis_tlast}, {63'd0, q[0].last});
                    if (m_axis_tready) begin
                        idx = 5 - q.size();
                        cap[idx] = m_axis_tdata;
                        beats++;
                        if (q[0].last) begin
                            model_seq = model_seq + 16'd1;
                            nlast++;
                        end
                        void'(q.pop_front());
                    end
                end else if (req_valid) begin
                    push_pkt(cur, model_seq);
                    n_acc++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_acc(input int target);
        int budget = 0;
        while (n_acc < target && budget < 300) begin
            @(posedge clk);
            budget++;
        end
        check("accept", 64'(n_acc), 64'(target));
    endtask

    task automatic send(input req_t r);
        int t0;
        cur       = r;
        req_valid = 1'b1;
        t0        = n_acc;
        wait_acc(t0 + 1);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (q.size() != 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("idle_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        req_t ra, rb;
        int   b0;
        int   l0;
        rst       = 1'b1;
        req_valid = 1'b0;
        cur       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_seq", {48'd0, seq_num}, 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);

        // Single packet, tready held high
        ra = '0;
        ra.dst = 16'h0012;
        ra.src = 16'h0034;
        ra.status = 4'd2;
        ra.cap_bytes = 40'h12_3456_789A;
        ra.cap_pkts = 24'hABCDEF;
        ra.xfer_pkts = 40'h01_0203_0405;
        ra.xfer_bytes = 64'h1122_3344_5566_7788;
        ra.buff_info = 16'hBEEF;
        ra.status_info = 48'hCAFE_0000_1234;
        b0 = beats;
        send(ra);
        repeat (5) @(posedge clk);
        #1;
        check("t1_beats", 64'(beats), 64'(b0 + 5));
        check("t1_hdr", cap[0], 64'h0080_0000_0028_0012);
        check("t1_w0", cap[1], 64'h1234_5678_9A02_0034);
        check("t1_seq", {48'd0, seq_num}, 64'd1);

        // Restart the sequence, then 100 packets with random back-pressure
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_mode = 1'b1;
        b0 = beats;
        l0 = nlast;
        for (int i = 0; i < 100; i++) begin
            send(rand_req());
        end
        wait_idle();
        rand_mode = 1'b0;
        tready_fix = 1'b1;
        check("t2_beats", 64'(beats), 64'(b0 + 500));
        check("t2_pkts", 64'(nlast), 64'(l0 + 100));
        check("t2_seq", {48'd0, seq_num}, 64'd100);

        // req_valid held high, fields changed while the first packet is in W1
        ra = rand_req();
        rb = rand_req();
        cur = ra;
        req_valid = 1'b1;
        b0 = n_acc;
        wait_acc(b0 + 1);
        repeat (2) @(posedge clk);
        #1;
        cur = rb;
        wait_acc(b0 + 2);
        #1;
        req_valid = 1'b0;
        wait_idle();
        check("t3_src_b", {48'd0, cap[1][15:0]}, {48'd0, rb.src});

        // Status 0xF and all-ones counters
        ra = '1;
        ra.dst = 16'h0101;
        ra.src = 16'h0202;
        send(ra);
        wait_idle();
        check("t4_w0_status", {56'd0, cap[1][23:16]}, 64'h0F);
        check("t4_w1", cap[2], '1);
        check("t4_w2", cap[3], '1);
        check("t4_w3", cap[4], '1);

        // Reset while stalled in W2
        b0 = beats;
        l0 = nlast;
        send(rand_req());
        begin
            int budget = 0;
            while (beats < b0 + 3 && budget < 50) begin
                @(posedge clk);
                budget++;
            end
        end
        #1;
        tready_fix = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("t5_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("t5_seq", {48'd0, seq_num}, 64'd0);
        check("t5_beats", 64'(beats), 64'(b0 + 3));
        tready_fix = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_nolast", 64'(nlast), 64'(l0));
        send(rand_req());
        wait_idle();
        check("t5_hdr_seq", {48'd0, cap[0][47:32]}, 64'd0);

        // Sequence wrap: preload the counter near the top instead of
        // streaming 65k packets
        force dut.seq_q = 16'hFFFE;
        model_seq = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.seq_q;
        send(rand_req());
        wait_idle();
        check("t6_seq_fffe", {48'd0, cap[0][47:32]}, 64'hFFFE);
        send(rand_req());
        wait_idle();
        check("t6_seq_ffff", {48'd0, cap[0][47:32]}, 64'hFFFF);
        check("t6_wrap_out", {48'd0, seq_num}, 64'd0);
        send(rand_req());
        wait_idle();
        check("t6_seq_0000", {48'd0, cap[0][47:32]}, 64'h0000);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
